// File: rtl/multich_interpolator.sv
// N-channel integer-factor interpolator: zero-stuff, zero-order hold or linear.
// One shared burst FSM paces L output vectors per accepted input; each channel has its own datapath lane.

module multich_interpolator_lane #(
  parameter int DATA_W = 16,
  parameter int LOG2_L = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic                     lin_i,
  input  logic                     hold_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_o
);
  localparam int AW = DATA_W + LOG2_L + 1;
  localparam int DW = DATA_W + 1;

  logic signed [DATA_W-1:0] cur_q, prev_q, dout_q, dout_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [DW-1:0]     diff;

  assign diff   = DW'(cur_q) - DW'(prev_q);
  assign dout_o = dout_q;

  // On load the old cur becomes prev, so the linear phase-0 output is the old cur.
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    if (load_i) begin
      acc_d  = AW'(cur_q) <<< LOG2_L;
      dout_d = lin_i ? cur_q : din_i;
    end else if (step_i) begin
      acc_d  = acc_q + AW'(diff);
      if (lin_i)       dout_d = DATA_W'(acc_d >>> LOG2_L);
      else if (hold_i) dout_d = cur_q;
      else             dout_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q  <= '0;
      prev_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
      if (load_i) begin
        prev_q <= cur_q;
        cur_q  <= din_i;
      end
    end
  end
endmodule

module multich_interpolator #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int LOG2_L = 1,
  parameter int STRIDE = 1
) (
  input  logic                     clk_32M768,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [NUM_CH*DATA_W-1:0] in_tdata,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [NUM_CH*DATA_W-1:0] out_tdata,
  output logic                     out_tvalid,
  output logic [LOG2_L-1:0]        out_phase,
  output logic                     overrun,
  input  logic                     overrun_clr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [LOG2_L-1:0] KMAX = '1;
  localparam logic [SW-1:0]     SMAX = SW'(STRIDE - 1);

  logic [0:0]        state_q, state_d;
  logic [LOG2_L-1:0] k_q, k_d, phase_q, phase_d;
  logic [SW-1:0]     s_q, s_d;
  logic [1:0]        mode_q, mode_d, mode_eff;
  logic              vld_q, vld_d, ovr_q, ovr_d;
  logic              last, accept, step;

  // Ready in the final slot of a burst lets bursts chain with no gap.
  assign last      = (state_q == EMIT) && (k_q == KMAX) && (s_q == SMAX);
  assign in_tready = (state_q == IDLE) || last;
  assign accept    = in_tvalid && in_tready;
  assign step      = (state_q == EMIT) && (s_q == SMAX) && (k_q != KMAX);
  assign mode_eff  = accept ? mode : mode_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    mode_d  = mode_q;
    if (accept) begin
      state_d = EMIT;
      k_d     = '0;
      s_d     = '0;
      mode_d  = mode;
    end else if (state_q == EMIT) begin
      if (last) begin
        state_d = IDLE;
        k_d     = '0;
        s_d     = '0;
      end else if (s_q == SMAX) begin
        k_d = k_q + 1'b1;
        s_d = '0;
      end else begin
        s_d = s_q + 1'b1;
      end
    end
    vld_d   = accept || step;
    phase_d = accept ? '0 : (step ? k_q + 1'b1 : phase_q);
    ovr_d   = (in_tvalid && !in_tready) || (ovr_q && !overrun_clr);
  end

  always_ff @(posedge clk_32M768) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      mode_q  <= '0;
      vld_q   <= 1'b0;
      phase_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      vld_q   <= vld_d;
      phase_q <= phase_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_tvalid = vld_q;
  assign out_phase  = phase_q;
  assign overrun    = ovr_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    multich_interpolator_lane #(.DATA_W(DATA_W), .LOG2_L(LOG2_L)) u_lane (
      .clk_i  (clk_32M768),
      .rst_i  (rst),
      .load_i (accept),
      .step_i (step),
      .lin_i  (mode_eff == 2'd2),
      .hold_i (mode_eff == 2'd1),
      .din_i  (in_tdata[ch*DATA_W +: DATA_W]),
      .dout_o (out_tdata[ch*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_multich_interpolator.sv
// Directed bench: three interpolator configurations share one stimulus bus; each test watches one of them.
module tb_multich_interpolator;
  logic        clk = 1'b0;
  logic        rst, in_tvalid, overrun_clr;
  logic [1:0]  mode;
  logic [31:0] in_tdata;

  logic        rdy [3];
  logic        vld [3];
  logic        orn [3];
  logic [31:0] dat [3];
  logic [1:0]  ph  [3];
  logic        ph_a, ph_c;
  logic [1:0]  ph_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u_a: L=2 STRIDE=1, u_b: L=4 STRIDE=3, u_c: L=2 STRIDE=2
  multich_interpolator #(.DATA_W(16), .NUM_CH(2), .LOG2_L(1), .STRIDE(1)) u_a (
    .clk_32M768(clk), .rst(rst), .mode(mode), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(rdy[0]), .out_tdata(dat[0]), .out_tvalid(vld[0]), .out_phase(ph_a),
    .overrun(orn[0]), .overrun_clr(overrun_clr));
  multich_interpolator #(.DATA_W(16), .NUM_CH(2), .LOG2_L(2), .STRIDE(3)) u_b (
    .clk_32M768(clk), .rst(rst), .mode(mode), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(rdy[1]), .out_tdata(dat[1]), .out_tvalid(vld[1]), .out_phase(ph_b),
    .overrun(orn[1]), .overrun_clr(overrun_clr));
  multich_interpolator #(.DATA_W(16), .NUM_CH(2), .LOG2_L(1), .STRIDE(2)) u_c (
    .clk_32M768(clk), .rst(rst), .mode(mode), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(rdy[2]), .out_tdata(dat[2]), .out_tvalid(vld[2]), .out_phase(ph_c),
    .overrun(orn[2]), .overrun_clr(overrun_clr));

  assign ph[0] = {1'b0, ph_a};
  assign ph[1] = ph_b;
  assign ph[2] = {1'b0, ph_c};

  typedef struct {
    logic [1:0]       m;
    logic [15:0]      d;
    logic [3:0][15:0] e;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic [1:0] m, input int d, input int e0, input int e1,
                              input int e2, input int e3);
    vec_t v;
    v.m = m;
    v.d = 16'(d);
    v.e[0] = 16'(e0);
    v.e[1] = 16'(e1);
    v.e[2] = 16'(e2);
    v.e[3] = 16'(e3);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    overrun_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for ready, present one vector, then check every cycle of the burst.
  task automatic burst(input int u, input int lg, input int s, input logic [1:0] m,
                       input logic [31:0] din, input logic [3:0][31:0] ex);
    int n = 0;
    int L = 1 << lg;
    while (!rdy[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d ready_start", u), 32'(rdy[u]), 32'd1);
    mode = m;
    in_tdata = din;
    in_tvalid = 1'b1;
    for (int j = 0; j < L * s; j++) begin
      @(negedge clk);
      in_tvalid = 1'b0;
      mode = 2'd2 ^ m;
      in_tdata = ~din;
      if (j % s == 0) begin
        chk($sformatf("u%0d strobe j%0d", u, j), 32'(vld[u]), 32'd1);
        chk($sformatf("u%0d phase j%0d", u, j), 32'(ph[u]), 32'(j / s));
        chk($sformatf("u%0d data j%0d", u, j), dat[u], ex[j / s]);
      end else begin
        chk($sformatf("u%0d gap j%0d", u, j), 32'(vld[u]), 32'd0);
      end
    end
    chk($sformatf("u%0d ready_end", u), 32'(rdy[u]), 32'd1);
  endtask

  initial begin
    logic [3:0][31:0] ex;
    rst = 1'b1;
    mode = 2'd0;
    in_tdata = '0;
    in_tvalid = 1'b0;
    overrun_clr = 1'b0;

    tbl[0] = mk(2'd1, 7,      7,      7,      7,      7);
    tbl[1] = mk(2'd2, 0,      7,      5,      3,      1);
    tbl[2] = mk(2'd2, 100,    0,      25,     50,     75);
    tbl[3] = mk(2'd2, -3,     100,    74,     48,     22);
    tbl[4] = mk(2'd2, -32768, -3,     -8195,  -16386, -24577);
    tbl[5] = mk(2'd2, 32767,  -32768, -16385, -1,     16383);
    tbl[6] = mk(2'd0, 5,      5,      0,      0,      0);
    tbl[7] = mk(2'd3, 9,      9,      0,      0,      0);
    tbl[8] = mk(2'd2, 8,      9,      8,      8,      8);

    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d rst vld", u), 32'(vld[u]), 32'd0);
      chk($sformatf("u%0d rst data", u), dat[u], 32'd0);
      chk($sformatf("u%0d rst phase", u), 32'(ph[u]), 32'd0);
      chk($sformatf("u%0d rst overrun", u), 32'(orn[u]), 32'd0);
      chk($sformatf("u%0d rst ready", u), 32'(rdy[u]), 32'd1);
    end
    rst = 1'b0;

    // Zero-stuff, I=1000 in channel 0, Q=-500 in channel 1
    ex = '0;
    ex[0] = {16'hFE0C, 16'd1000};
    burst(0, 1, 1, 2'd0, {16'hFE0C, 16'd1000}, ex);

    // Hold / linear / zero-stuff vector table on the L=4, STRIDE=3 instance
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int p = 0; p < 4; p++) ex[p] = {tbl[i].e[p], tbl[i].e[p]};
      burst(1, 2, 3, tbl[i].m, {tbl[i].d, tbl[i].d}, ex);
    end

    // Back-to-back hold bursts: continuous output every 2 cycles, no overrun
    do_reset();
    for (int v = 0; v < 8; v++) begin
      ex = '0;
      ex[0] = {16'(v + 11), 16'(v + 1)};
      ex[1] = ex[0];
      burst(2, 1, 2, 2'd1, ex[0], ex);
    end
    chk("b2b overrun", 32'(orn[2]), 32'd0);

    // Early input is dropped and flags overrun; the burst is untouched
    mode = 2'd1; in_tdata = {16'd100, 16'd100}; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("ovr ph0 data", dat[2], {16'd100, 16'd100});
    @(negedge clk);
    chk("ovr gap", 32'(vld[2]), 32'd0);
    chk("ovr ready low", 32'(rdy[2]), 32'd0);
    mode = 2'd1; in_tdata = {16'd555, 16'd555}; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("ovr ph1 strobe", 32'(vld[2]), 32'd1);
    chk("ovr ph1 data", dat[2], {16'd100, 16'd100});
    chk("ovr flag set", 32'(orn[2]), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr clr alone", 32'(orn[2]), 32'd0);
    chk("ovr ready back", 32'(rdy[2]), 32'd1);

    // Linear from prev=100 proves the dropped vector left cur alone; then clear vs new event
    mode = 2'd2; in_tdata = {16'd200, 16'd200}; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("lin2 ph0 data", dat[2], {16'd100, 16'd100});
    @(negedge clk);
    chk("lin2 ready low", 32'(rdy[2]), 32'd0);
    in_tdata = {16'd777, 16'd777}; in_tvalid = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0; overrun_clr = 1'b0;
    chk("lin2 ph1 data", dat[2], {16'd150, 16'd150});
    chk("clr vs event", 32'(orn[2]), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("clr after event", 32'(orn[2]), 32'd0);

    // Reset in the middle of an L=4 burst, then linear restarts from prev=0
    do_reset();
    mode = 2'd1; in_tdata = {16'd7, 16'd7}; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("mid ph0", 32'(vld[1]), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid ph1 strobe", 32'(vld[1]), 32'd1);
    chk("mid ph1 phase", 32'(ph[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst vld", 32'(vld[1]), 32'd0);
    chk("mid rst data", dat[1], 32'd0);
    chk("mid rst phase", 32'(ph[1]), 32'd0);
    chk("mid rst ready", 32'(rdy[1]), 32'd1);
    ex[0] = {16'd0, 16'd0};
    ex[1] = {16'd10, 16'd10};
    ex[2] = {16'd20, 16'd20};
    ex[3] = {16'd30, 16'd30};
    burst(1, 2, 3, 2'd2, {16'd40, 16'd40}, ex);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
